// File: rtl/ddr_pix_gearbox_if.sv
// ddr_pix_gearbox_if
//   Bundles the DDR read-return side and the pixel stream side of the
//   ddr_pix_gearbox into one interface.
//   master : the gearbox itself (drives rd_start, the pixel stream and status)
//   slave  : the environment (DDR read controller + downstream consumer)
//   Signals:
//     rd_start       burst request pulse towards the DDR read controller
//     user_rd_end    pulse marking the end of the current burst
//     rd_data_valid  rd_data carries a beat this cycle
//     rd_data        returned DDR beat, IN_W bits
//     flush          frame resync, discards buffered and in-flight data
//     pix_valid      pix_data is valid
//     pix_ready      downstream accepts pix_data
//     pix_data       current output word, OUT_W bits
//     fill_level     beats currently stored
//     overflow       sticky: beat dropped because the buffer was full
//     underflow      sticky: consumer was ready while no word was available
interface ddr_pix_gearbox_if #(
    parameter int IN_W  = 512,
    parameter int OUT_W = 64,
    parameter int DEPTH = 16
);
    logic                   rd_start;
    logic                   user_rd_end;
    logic                   rd_data_valid;
    logic [IN_W-1:0]        rd_data;
    logic                   flush;
    logic                   pix_valid;
    logic                   pix_ready;
    logic [OUT_W-1:0]       pix_data;
    logic [$clog2(DEPTH):0] fill_level;
    logic                   overflow;
    logic                   underflow;

    modport master (
        output rd_start, pix_valid, pix_data, fill_level, overflow, underflow,
        input  user_rd_end, rd_data_valid, rd_data, flush, pix_ready
    );

    modport slave (
        input  rd_start, pix_valid, pix_data, fill_level, overflow, underflow,
        output user_rd_end, rd_data_valid, rd_data, flush, pix_ready
    );
endinterface

// File: rtl/ddr_pix_gearbox.sv
// ddr_pix_gearbox
//   Single-clock DDR read-return buffer and pixel down-converter. Requests
//   bursts of BURST_LEN beats whenever the internal FIFO has room for a whole
//   burst, stores the returned IN_W-bit beats, and serialises each stored beat
//   into IN_W/OUT_W words on a valid/ready stream, least significant lane first.
//   Ports:
//     wrclk  clock, all logic on the rising edge
//     rst    asynchronous active-high reset
//     bus    ddr_pix_gearbox_if.master (see the interface file for signals)
module ddr_pix_gearbox #(
    parameter int IN_W      = 512,
    parameter int OUT_W     = 64,
    parameter int DEPTH     = 16,
    parameter int BURST_LEN = 8
) (
    input  logic                wrclk,
    input  logic                rst,
    ddr_pix_gearbox_if.master   bus
);

    localparam int RATIO  = IN_W / OUT_W;
    localparam int LANE_W = $clog2(RATIO);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        JUDGE,
        RD,
        FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic                rd_start_q, rd_start_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                arm_q, arm_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic [IN_W-1:0]     mem_q [DEPTH];

    logic                head_valid;
    logic                accept;
    logic                last_lane;
    logic                beat_pop;
    logic                beat_in;
    logic                push;
    logic                drop;
    logic [CNT_W-1:0]    free_beats;

    // Handshake decode. flush overrides any push or pop in the same cycle,
    // and beats arriving while the FSM waits out a flushed burst are discarded
    // without counting as an overflow.
    always_comb begin
        head_valid = (count_q != '0);
        accept     = head_valid && bus.pix_ready;
        last_lane  = (lane_q == LANE_W'(RATIO - 1));
        beat_pop   = accept && last_lane && !bus.flush;
        beat_in    = bus.rd_data_valid && !bus.flush && (state_q != FLUSH);
        // A pop on the same edge frees the slot, so a full FIFO can still take a beat.
        push       = beat_in && ((count_q < CNT_W'(DEPTH)) || beat_pop);
        drop       = beat_in && !push;
        free_beats = CNT_W'(DEPTH) - count_q;
    end

    // Request FSM: a burst is only requested when a complete burst fits.
    always_comb begin
        state_d    = state_q;
        rd_start_d = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = JUDGE;
            end
            JUDGE: begin
                if (!bus.flush && (free_beats >= CNT_W'(BURST_LEN))) begin
                    state_d    = RD;
                    rd_start_d = 1'b1;
                end
            end
            RD: begin
                // The burst end wins over flush: nothing more is in flight.
                if (bus.user_rd_end) begin
                    state_d = JUDGE;
                end else if (bus.flush) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (bus.user_rd_end) begin
                    state_d = JUDGE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO pointers, occupancy, output lane and status flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        lane_d      = lane_q;
        arm_d       = arm_q;
        overflow_d  = overflow_q | drop;
        underflow_d = underflow_q | (arm_q && bus.pix_ready && !head_valid);
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            lane_d   = '0;
            arm_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (beat_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, beat_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            // RATIO is a power of two, so the lane counter wraps on its own.
            if (accept) begin
                lane_d = lane_q + LANE_W'(1);
                arm_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge wrclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_start_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lane_q      <= '0;
            arm_q       <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_start_q  <= rd_start_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            lane_q      <= lane_d;
            arm_q       <= arm_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Beat storage has no reset; slots are only read after being written.
    always_ff @(posedge wrclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.rd_data;
        end
    end

    assign bus.rd_start   = rd_start_q;
    assign bus.pix_valid  = head_valid;
    assign bus.pix_data   = mem_q[rd_ptr_q][lane_q*OUT_W +: OUT_W];
    assign bus.fill_level = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;

endmodule

// File: tb/tb_ddr_pix_gearbox.sv
// tb_ddr_pix_gearbox
//   Directed self-checking bench for ddr_pix_gearbox. Every driven beat that
//   should be accepted pushes its output words into a scoreboard queue; every
//   word the DUT hands over is popped and compared in order.
module tb_ddr_pix_gearbox;

    localparam int IN_W      = 512;
    localparam int OUT_W     = 64;
    localparam int DEPTH     = 16;
    localparam int BURST_LEN = 8;
    localparam int RATIO     = IN_W / OUT_W;

    logic wrclk = 1'b0;
    logic rst;

    always #5 wrclk = ~wrclk;

    ddr_pix_gearbox_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

    ddr_pix_gearbox #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN)
    ) dut (
        .wrclk(wrclk),
        .rst(rst),
        .bus(bus)
    );

    int               checks   = 0;
    int               failures = 0;
    int               beat_no  = 0;
    logic [OUT_W-1:0] sb [$];

    // Lane k of beat b: 0x0706050403020100 pattern stepped per lane, top byte tagged with b.
    function automatic logic [OUT_W-1:0] word_of(input int b, input int k);
        logic [OUT_W-1:0] base;
        base = 64'h0706050403020100 + 64'(k) * 64'h0808080808080808;
        return base ^ {8'(b), 56'h0};
    endfunction

    function automatic logic [IN_W-1:0] beat_of(input int b);
        logic [IN_W-1:0] v;
        v = '0;
        for (int k = 0; k < RATIO; k++) begin
            v[k*OUT_W +: OUT_W] = word_of(b, k);
        end
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: sample at the falling edge, drive inputs for the next
    // rising edge, and keep the scoreboard in step with what that edge does.
    task automatic applyStimulus(input logic valid, input logic accepted,
                                 input logic rd_end, input logic flsh,
                                 input logic ready);
        @(negedge wrclk);
        checkOutput("pix_valid", 64'(bus.pix_valid), 64'(sb.size() != 0));
        bus.rd_data_valid = valid;
        bus.rd_data       = valid ? beat_of(beat_no) : '0;
        bus.user_rd_end   = rd_end;
        bus.flush         = flsh;
        bus.pix_ready     = ready;
        if (flsh) begin
            sb.delete();
        end else if (bus.pix_valid && ready && (sb.size() != 0)) begin
            checkOutput("pix_data", bus.pix_data, sb.pop_front());
        end
        if (valid) begin
            if (accepted) begin
                for (int k = 0; k < RATIO; k++) begin
                    sb.push_back(word_of(beat_no, k));
                end
            end
            beat_no++;
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_rd_start"}, 64'(bus.rd_start), 64'd0);
        checkOutput({tag, "_pix_valid"}, 64'(bus.pix_valid), 64'd0);
        checkOutput({tag, "_fill"}, 64'(bus.fill_level), 64'd0);
        checkOutput({tag, "_overflow"}, 64'(bus.overflow), 64'd0);
        checkOutput({tag, "_underflow"}, 64'(bus.underflow), 64'd0);
    endtask

    initial begin
        rst               = 1'b1;
        bus.rd_data_valid = 1'b0;
        bus.rd_data       = '0;
        bus.user_rd_end   = 1'b0;
        bus.flush         = 1'b0;
        bus.pix_ready     = 1'b0;
        repeat (2) @(negedge wrclk);
        checkReset("reset");
        rst = 1'b0;

        // T1: first request two cycles after release, one full burst, second request
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t1_rd_start_early", 64'(bus.rd_start), 64'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t1_rd_start", 64'(bus.rd_start), 64'd1);
        for (int i = 0; i < BURST_LEN; i++) begin
            applyStimulus(1, 1, 0, 0, 0);
            if (i == 0) checkOutput("t1_rd_start_pulse", 64'(bus.rd_start), 64'd0);
        end
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("t1_fill", 64'(bus.fill_level), 64'd8);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t1_rd_start2_early", 64'(bus.rd_start), 64'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t1_rd_start2", 64'(bus.rd_start), 64'd1);

        // T2: one beat drained at one word per cycle
        for (int i = 0; i < RATIO; i++) applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t2_fill_mid", 64'(bus.fill_level), 64'd8);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t2_fill_after", 64'(bus.fill_level), 64'd7);

        // T3: alternating ready
        for (int i = 0; i < 2 * RATIO; i++) applyStimulus(0, 0, 0, 0, (i % 2) == 0);
        checkOutput("t3_fill", 64'(bus.fill_level), 64'd6);
        checkOutput("t3_underflow", 64'(bus.underflow), 64'd0);

        // Second burst returns; 16-14 < 8 so no further request
        for (int i = 0; i < BURST_LEN; i++) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("t4_fill14", 64'(bus.fill_level), 64'd14);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t4_no_request", 64'(bus.rd_start), 64'd0);

        // T4: fill to 16, drop a 17th beat, then accept one with a same-cycle pop
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t4_fill16", 64'(bus.fill_level), 64'd16);
        checkOutput("t4_overflow_before", 64'(bus.overflow), 64'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t4_overflow", 64'(bus.overflow), 64'd1);
        checkOutput("t4_fill_drop", 64'(bus.fill_level), 64'd16);
        for (int i = 0; i < RATIO - 1; i++) applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t4_fill_pushpop", 64'(bus.fill_level), 64'd16);
        checkOutput("t4_overflow_held", 64'(bus.overflow), 64'd1);

        // T5: flush while judging, then flush mid-burst after 3 beats
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t5_fill_flush", 64'(bus.fill_level), 64'd0);
        checkOutput("t5_rd_start_early", 64'(bus.rd_start), 64'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t5_rd_start", 64'(bus.rd_start), 64'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("t5_fill3", 64'(bus.fill_level), 64'd3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 0, 1);
            checkOutput("t5_fill_discard", 64'(bus.fill_level), 64'd0);
        end
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("t5_fill_end", 64'(bus.fill_level), 64'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t5_rd_start2_early", 64'(bus.rd_start), 64'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t5_rd_start2", 64'(bus.rd_start), 64'd1);
        checkOutput("t5_overflow_sticky", 64'(bus.overflow), 64'd1);
        checkOutput("t5_underflow", 64'(bus.underflow), 64'd0);

        // T6: drain to empty with ready high, then asynchronous reset mid-burst
        applyStimulus(1, 1, 0, 0, 0);
        for (int i = 0; i < RATIO; i++) applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t6_underflow_before", 64'(bus.underflow), 64'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t6_underflow", 64'(bus.underflow), 64'd1);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t6_fill_pre_reset", 64'(bus.fill_level), 64'd1);
        #2 rst = 1'b1;
        #1 checkReset("t6_async_reset");
        sb.delete();
        @(negedge wrclk);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t6_rd_start_after_reset", 64'(bus.rd_start), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
